lsu_req_tracker: RTL and testbench
==================================

LSU_REQ_TRACKER -- requirements
Module: lsu_req_tracker

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the maximum outstanding data requests; it SHALL be a power of 2 and at least 2.
REQ-002 Parameter CNT_W, default $clog2(DEPTH+1), SHALL set the width of occ.
REQ-003 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-004 rstn  in  1  reset: synchronous, active-low.
REQ-005 in_valid/in_ready  in/out  1/1  op handshake from execute.
REQ-006 in_we  in  1  store (1) or load (0).
REQ-007 in_size  in  2  0=byte, 1=half, 2=word; 3 SHALL be treated as word.
REQ-008 in_signed  in  1  sign-extend load data.
REQ-009 in_addr  in  32  physical byte address.
REQ-010 in_wdata  in  32  store data, in low bits.
REQ-011 in_dest  in  5  load destination register.
REQ-012 flush  in  1  kill all in-flight ops.
REQ-013 data_sram_req/wr/size/wstrb/addr/wdata  out  1/1/2/4/32/32  bus request.
REQ-014 data_sram_addr_ok, data_sram_data_ok  in  1 each; data_sram_rdata  in  32.
REQ-015 out_valid  out  1  one-cycle writeback pulse.
REQ-016 out_rdata  out  32  formatted load data (0 for stores).
REQ-017 out_dest  out  5  destination register; out_is_store  out  1  completed op was a store.
REQ-018 ex_ale  out  1  one-cycle misalignment pulse.
REQ-019 ale_addr  out  32  address of the misaligned op.
REQ-020 occ  out  CNT_W  tracker entries plus the issue register.
REQ-021 busy  out  1  busy = (occ != 0).

Function
REQ-022 Handshake: in_ready SHALL equal !flush && (!iss_v || data_sram_addr_ok) && (occ < DEPTH); transfer occurs when in_valid && in_ready.
REQ-023 Misaligned op: half with addr[0]=1, or word with addr[1:0]!=0.
- SHALL be accepted, then pulse ex_ale and load ale_addr one cycle later.
- SHALL NOT load the issue register or generate a bus request.
REQ-024 Aligned op SHALL load the issue register (iss_v=1) at the next edge.
REQ-025 data_sram_req SHALL equal iss_v; a request SHALL remain asserted with stable fields until data_sram_addr_ok, including across flush.
REQ-026 data_sram_addr = iss addr; data_sram_wr = iss we.
REQ-027 Store encoding:
- byte: wstrb=0001<<addr[1:0], wdata = byte replicated x4.
- half: wstrb=0011<<addr[1:0], wdata = half replicated x2.
- word: wstrb=1111, wdata as given.
- data_sram_size = in_size (3 maps to 2).
- Loads: wstrb=0000.
REQ-028 On req && addr_ok, an entry {we, size, signed, addr[1:0], dest, killed} SHALL be pushed at the tail pointer (mod DEPTH); killed is set if flush is high in that cycle.
REQ-029 On data_ok with occ-entries > 0, the head entry SHALL be popped.
- If not killed: next cycle out_valid=1, out_dest=entry dest, out_is_store=entry we.
- out_rdata = rdata >> (8*addr[1:0]), truncated to size, sign- or zero-extended.
REQ-030 data_ok with zero tracker entries SHALL be ignored; a push and a pop in the same cycle SHALL leave the entry count unchanged.
REQ-031 flush SHALL set killed on all valid tracker entries.
- Killed entries still consume data_ok but produce no out_valid.
- A flush asserted in the same cycle as data_ok SHALL suppress that completion.
REQ-032 Completions SHALL be returned strictly in issue order; occ SHALL never exceed DEPTH.

Reset
REQ-033 With rstn=0 at an edge, the block SHALL clear iss_v, pointers, entry count, all killed bits, out_valid, and ex_ale.
REQ-034 During and after reset, all outputs SHALL be 0, except in_ready=1 once reset is released.

Verification
REQ-035 Load byte at 0x1003, signed, rdata=0x80FF_FF12 -> one req with wstrb=0000, size=0; after data_ok, next-cycle out_valid=1, out_rdata=0xFFFFFF80.
REQ-036 Store half at 0x2002, wdata=0x1234 -> wstrb=1100, size=1, data_sram_wdata=0x12341234; data_ok -> out_is_store=1, out_rdata=0.
REQ-037 Word load at 0x3001 -> ex_ale pulse, ale_addr=0x3001, no data_sram_req, occ=0.
REQ-038 DEPTH=4, addr_ok always 1, data_ok withheld, 5 loads offered -> in_ready=0 once occ=4; 4 data_ok pulses -> 4 in-order completions with correct dest values.
REQ-039 Three loads outstanding, flush pulse, then three data_ok -> no out_valid; a subsequent load completes normally with occ returning to 0.
REQ-040 rstn=0 for one cycle while two ops are in flight -> occ=0, out_valid=0, busy=0 next cycle; late data_ok ignored.

Source files
------------

// File: rtl/lsu_req_tracker.sv
`default_nettype none
// ============================================================================
// Module  : lsu_req_tracker
// Brief   : LSU issue register plus in-order tracker for outstanding data-SRAM
//           requests, with load formatting, misalignment and flush handling.
// Rev     : 1.0  initial release
// ============================================================================
module lsu_req_tracker #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_we,
    input  logic [1:0]       in_size,
    input  logic             in_signed,
    input  logic [31:0]      in_addr,
    input  logic [31:0]      in_wdata,
    input  logic [4:0]       in_dest,
    input  logic             flush,
    output logic             data_sram_req,
    output logic             data_sram_wr,
    output logic [1:0]       data_sram_size,
    output logic [3:0]       data_sram_wstrb,
    output logic [31:0]      data_sram_addr,
    output logic [31:0]      data_sram_wdata,
    input  logic             data_sram_addr_ok,
    input  logic             data_sram_data_ok,
    input  logic [31:0]      data_sram_rdata,
    output logic             out_valid,
    output logic [31:0]      out_rdata,
    output logic [4:0]       out_dest,
    output logic             out_is_store,
    output logic             ex_ale,
    output logic [31:0]      ale_addr,
    output logic [CNT_W-1:0] occ,
    output logic             busy
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    // Issue register: the single op currently presented on the bus
    logic             r_iss_v;
    logic             r_iss_killed;
    logic             r_iss_we;
    logic [1:0]       r_iss_size;
    logic             r_iss_signed;
    logic [31:0]      r_iss_addr;
    logic [31:0]      r_iss_wdata;
    logic [4:0]       r_iss_dest;

    // Tracker ring of ops whose address phase completed
    logic             r_e_we     [DEPTH];
    logic [1:0]       r_e_size   [DEPTH];
    logic             r_e_signed [DEPTH];
    logic [1:0]       r_e_off    [DEPTH];
    logic [4:0]       r_e_dest   [DEPTH];
    logic [DEPTH-1:0] r_e_killed;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_cnt;

    logic             r_out_valid;
    logic [31:0]      r_out_rdata;
    logic [4:0]       r_out_dest;
    logic             r_out_is_store;
    logic             r_ex_ale;
    logic [31:0]      r_ale_addr;

    logic [1:0]       w_size;
    logic             w_mis;
    logic             w_fire;
    logic             w_push;
    logic             w_pop;
    logic             w_complete;
    logic [CNT_W-1:0] w_occ;
    logic [31:0]      w_wdata;
    logic [3:0]       w_wstrb;
    logic [31:0]      w_shifted;
    logic [31:0]      w_fmt;

    assign w_size = (in_size == 2'd3) ? 2'd2 : in_size;
    assign w_mis  = ((w_size == 2'd1) && in_addr[0]) ||
                    ((w_size == 2'd2) && (in_addr[1:0] != 2'b00));
    assign w_occ  = r_cnt + CNT_W'(r_iss_v);

    assign in_ready = rstn && !flush && (!r_iss_v || data_sram_addr_ok) && (w_occ < c_depth);
    assign w_fire   = in_valid && in_ready;
    assign w_push   = r_iss_v && data_sram_addr_ok;
    assign w_pop    = data_sram_data_ok && (r_cnt != '0);
    // A flush in the completing cycle also suppresses the writeback
    assign w_complete = w_pop && !r_e_killed[r_head] && !flush;

    always_comb begin
        case (w_size)
            2'd0:    w_wdata = {4{in_wdata[7:0]}};
            2'd1:    w_wdata = {2{in_wdata[15:0]}};
            default: w_wdata = in_wdata;
        endcase
    end

    always_comb begin
        w_wstrb = 4'b0000;
        if (r_iss_we) begin
            case (r_iss_size)
                2'd0:    w_wstrb = 4'b0001 << r_iss_addr[1:0];
                2'd1:    w_wstrb = 4'b0011 << r_iss_addr[1:0];
                default: w_wstrb = 4'b1111;
            endcase
        end
    end

    always_comb begin
        w_shifted = data_sram_rdata >> {r_e_off[r_head], 3'b000};
        case (r_e_size[r_head])
            2'd0:    w_fmt = {{24{r_e_signed[r_head] & w_shifted[7]}}, w_shifted[7:0]};
            2'd1:    w_fmt = {{16{r_e_signed[r_head] & w_shifted[15]}}, w_shifted[15:0]};
            default: w_fmt = w_shifted;
        endcase
    end

    // An op stuck in the issue register across a flush stays on the bus but
    // must still be dropped when it completes.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_iss_v      <= 1'b0;
            r_iss_killed <= 1'b0;
            r_iss_we     <= 1'b0;
            r_iss_size   <= 2'd0;
            r_iss_signed <= 1'b0;
            r_iss_addr   <= 32'd0;
            r_iss_wdata  <= 32'd0;
            r_iss_dest   <= 5'd0;
        end else if (w_fire && !w_mis) begin
            r_iss_v      <= 1'b1;
            r_iss_killed <= 1'b0;
            r_iss_we     <= in_we;
            r_iss_size   <= w_size;
            r_iss_signed <= in_signed;
            r_iss_addr   <= in_addr;
            r_iss_wdata  <= w_wdata;
            r_iss_dest   <= in_dest;
        end else if (w_push) begin
            r_iss_v      <= 1'b0;
            r_iss_killed <= 1'b0;
        end else if (flush && r_iss_v) begin
            r_iss_killed <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_e_we[r_tail]     <= r_iss_we;
            r_e_size[r_tail]   <= r_iss_size;
            r_e_signed[r_tail] <= r_iss_signed;
            r_e_off[r_tail]    <= r_iss_addr[1:0];
            r_e_dest[r_tail]   <= r_iss_dest;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_e_killed <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_cnt      <= '0;
        end else begin
            if (flush) begin
                r_e_killed <= '1;
            end
            if (w_push) begin
                r_e_killed[r_tail] <= flush | r_iss_killed;
                r_tail             <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_out_valid    <= 1'b0;
            r_out_rdata    <= 32'd0;
            r_out_dest     <= 5'd0;
            r_out_is_store <= 1'b0;
            r_ex_ale       <= 1'b0;
            r_ale_addr     <= 32'd0;
        end else begin
            r_out_valid    <= w_complete;
            r_out_rdata    <= (w_complete && !r_e_we[r_head]) ? w_fmt : 32'd0;
            r_out_dest     <= w_complete ? r_e_dest[r_head] : 5'd0;
            r_out_is_store <= w_complete && r_e_we[r_head];
            r_ex_ale       <= w_fire && w_mis;
            if (w_fire && w_mis) begin
                r_ale_addr <= in_addr;
            end
        end
    end

    assign data_sram_req   = r_iss_v;
    assign data_sram_wr    = r_iss_we;
    assign data_sram_size  = r_iss_size;
    assign data_sram_wstrb = w_wstrb;
    assign data_sram_addr  = r_iss_addr;
    assign data_sram_wdata = r_iss_wdata;

    assign out_valid    = r_out_valid;
    assign out_rdata    = r_out_rdata;
    assign out_dest     = r_out_dest;
    assign out_is_store = r_out_is_store;
    assign ex_ale       = r_ex_ale;
    assign ale_addr     = r_ale_addr;
    assign occ          = w_occ;
    assign busy         = (w_occ != '0);

endmodule
`default_nettype wire

// File: tb/tb_lsu_req_tracker.sv
`default_nettype none
// ============================================================================
// Module  : tb_lsu_req_tracker
// Brief   : Self-checking bench for lsu_req_tracker against a queue-based model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_lsu_req_tracker;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rstn;
    logic             in_valid, in_ready, in_we, in_signed, flush;
    logic [1:0]       in_size;
    logic [31:0]      in_addr, in_wdata;
    logic [4:0]       in_dest;
    logic             data_sram_req, data_sram_wr;
    logic [1:0]       data_sram_size;
    logic [3:0]       data_sram_wstrb;
    logic [31:0]      data_sram_addr, data_sram_wdata;
    logic             data_sram_addr_ok, data_sram_data_ok;
    logic [31:0]      data_sram_rdata;
    logic             out_valid, out_is_store, ex_ale, busy;
    logic [31:0]      out_rdata, ale_addr;
    logic [4:0]       out_dest;
    logic [CNT_W-1:0] occ;

    lsu_req_tracker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we), .in_size(in_size),
        .in_signed(in_signed), .in_addr(in_addr), .in_wdata(in_wdata), .in_dest(in_dest),
        .flush(flush),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .out_valid(out_valid), .out_rdata(out_rdata), .out_dest(out_dest),
        .out_is_store(out_is_store), .ex_ale(ex_ale), .ale_addr(ale_addr),
        .occ(occ), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        int          size;
        bit          sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  dest;
        bit          killed;
    } op_t;

    // Reference state: one pending bus op plus a FIFO of address-accepted ops
    bit          m_iss_v;
    op_t         m_iss;
    op_t         m_q[$];
    bit          m_ov, m_ostore, m_ale, m_fire;
    logic [31:0] m_ordata, m_ale_addr;
    logic [4:0]  m_odest;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int norm_size(input logic [1:0] s);
        return (s == 2'd3) ? 2 : int'(s);
    endfunction

    function automatic bit m_ready();
        return rstn && !flush && (!m_iss_v || data_sram_addr_ok) &&
               ((m_q.size() + int'(m_iss_v)) < DEPTH);
    endfunction

    function automatic logic [31:0] exp_load(input op_t e, input logic [31:0] rd);
        logic [31:0] s;
        logic [31:0] r;
        s = rd >> (8 * int'(e.addr[1:0]));
        if (e.size == 0) begin
            r = s & 32'hFF;
            if (e.sgn && s[7]) r = r | 32'hFFFF_FF00;
        end else if (e.size == 1) begin
            r = s & 32'hFFFF;
            if (e.sgn && s[15]) r = r | 32'hFFFF_0000;
        end else begin
            r = s;
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_wdata(input op_t e);
        if (e.size == 0) return (e.wdata & 32'hFF) * 32'h0101_0101;
        if (e.size == 1) return (e.wdata & 32'hFFFF) * 32'h0001_0001;
        return e.wdata;
    endfunction

    function automatic logic [31:0] exp_wstrb(input op_t e);
        int off;
        off = int'(e.addr[1:0]);
        if (!e.we) return 0;
        if (e.size == 0) return 32'(1 << off);
        if (e.size == 1) return 32'(3 << off);
        return 15;
    endfunction

    task automatic model_reset();
        m_iss_v = 0; m_q.delete();
        m_ov = 0; m_ostore = 0; m_ale = 0; m_fire = 0;
        m_ordata = 0; m_ale_addr = 0; m_odest = 0;
    endtask

    task automatic compare();
        int n;
        n = m_q.size() + int'(m_iss_v);
        chk("in_ready", in_ready, m_ready());
        chk("occ", occ, n);
        chk("occ_bound", occ <= DEPTH, 1);
        chk("busy", busy, n != 0);
        chk("req", data_sram_req, m_iss_v);
        if (m_iss_v) begin
            chk("sram_addr", data_sram_addr, m_iss.addr);
            chk("sram_wr", data_sram_wr, m_iss.we);
            chk("sram_size", data_sram_size, m_iss.size);
            chk("sram_wstrb", data_sram_wstrb, exp_wstrb(m_iss));
            if (m_iss.we) chk("sram_wdata", data_sram_wdata, exp_wdata(m_iss));
        end
        chk("out_valid", out_valid, m_ov);
        if (m_ov) begin
            chk("out_rdata", out_rdata, m_ordata);
            chk("out_dest", out_dest, m_odest);
            chk("out_is_store", out_is_store, m_ostore);
        end
        chk("ex_ale", ex_ale, m_ale);
        chk("ale_addr", ale_addr, m_ale_addr);
    endtask

    task automatic model_step();
        bit  fire, mis, push;
        int  sz;
        op_t e;
        if (!rstn) begin
            model_reset();
            return;
        end
        sz   = norm_size(in_size);
        fire = in_valid && m_ready();
        mis  = (sz == 1 && in_addr[0]) || (sz == 2 && in_addr[1:0] != 2'b00);
        push = m_iss_v && data_sram_addr_ok;
        m_fire = fire;
        m_ov = 0; m_ordata = 0; m_odest = 0; m_ostore = 0;
        if (data_sram_data_ok && m_q.size() > 0) begin
            e = m_q.pop_front();
            if (!e.killed && !flush) begin
                m_ov     = 1;
                m_odest  = e.dest;
                m_ostore = e.we;
                m_ordata = e.we ? 32'd0 : exp_load(e, data_sram_rdata);
            end
        end
        if (flush) foreach (m_q[i]) m_q[i].killed = 1;
        if (push) begin
            e = m_iss;
            e.killed = flush || m_iss.killed;
            m_q.push_back(e);
        end
        if (fire && !mis) begin
            m_iss_v = 1;
            m_iss = '{we: in_we, size: sz, sgn: in_signed, addr: in_addr,
                      wdata: in_wdata, dest: in_dest, killed: 0};
        end else if (push) begin
            m_iss_v = 0;
        end else if (flush && m_iss_v) begin
            m_iss.killed = 1;
        end
        m_ale = fire && mis;
        if (fire && mis) m_ale_addr = in_addr;
    endtask

    // Called at a falling edge with inputs already driven
    task automatic cycle();
        #1;
        compare();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        rstn = 1; in_valid = 0; in_we = 0; in_size = 0; in_signed = 0;
        in_addr = 0; in_wdata = 0; in_dest = 0; flush = 0;
        data_sram_addr_ok = 0; data_sram_data_ok = 0; data_sram_rdata = 0;
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] s, input logic sg, input logic [4:0] d);
        in_valid = 1; in_we = 0; in_size = s; in_signed = sg; in_addr = a; in_dest = d;
    endtask

    task automatic rand_inputs();
        logic [31:0] a;
        rstn      = ($urandom % 150) != 0;
        in_valid  = ($urandom % 10) < 6;
        in_we     = $urandom % 2;
        in_size   = 2'($urandom % 4);
        in_signed = $urandom % 2;
        a = $urandom;
        if ($urandom % 5 != 0) begin
            if (norm_size(in_size) == 2) a[1:0] = 2'b00;
            else if (norm_size(in_size) == 1) a[0] = 1'b0;
        end
        in_addr           = a;
        in_wdata          = $urandom;
        in_dest           = 5'($urandom % 32);
        flush             = ($urandom % 20) == 0;
        data_sram_addr_ok = ($urandom % 10) < 7;
        data_sram_data_ok = ($urandom % 10) < 4;
        data_sram_rdata   = $urandom;
    endtask

    initial begin
        int acc;
        idle();
        rstn = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        model_reset();
        #1;
        chk("rst_occ", occ, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req", data_sram_req, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ex_ale", ex_ale, 0);
        chk("rst_in_ready", in_ready, 0);
        rstn = 1;
        #1 chk("post_rst_in_ready", in_ready, 1);

        // Signed byte load at 0x1003
        load(32'h1003, 2'd0, 1, 5'd7);
        cycle();
        chk("lb_req", data_sram_req, 1);
        chk("lb_wstrb", data_sram_wstrb, 0);
        chk("lb_size", data_sram_size, 0);
        chk("lb_addr", data_sram_addr, 32'h1003);
        idle(); data_sram_addr_ok = 1;
        cycle();
        idle(); data_sram_data_ok = 1; data_sram_rdata = 32'h80FF_FF12;
        cycle();
        chk("lb_out_valid", out_valid, 1);
        chk("lb_out_rdata", out_rdata, 32'hFFFF_FF80);
        chk("lb_out_dest", out_dest, 7);
        idle(); cycle();

        // Half store at 0x2002
        in_valid = 1; in_we = 1; in_size = 2'd1; in_addr = 32'h2002; in_wdata = 32'h1234; in_dest = 3;
        cycle();
        chk("sh_wstrb", data_sram_wstrb, 4'b1100);
        chk("sh_size", data_sram_size, 1);
        chk("sh_wdata", data_sram_wdata, 32'h1234_1234);
        chk("sh_wr", data_sram_wr, 1);
        idle(); data_sram_addr_ok = 1;
        cycle();
        idle(); data_sram_data_ok = 1; data_sram_rdata = 32'hDEAD_BEEF;
        cycle();
        chk("sh_out_valid", out_valid, 1);
        chk("sh_is_store", out_is_store, 1);
        chk("sh_out_rdata", out_rdata, 0);
        idle(); cycle();

        // Misaligned word load
        load(32'h3001, 2'd2, 0, 5'd1);
        cycle();
        chk("ale_pulse", ex_ale, 1);
        chk("ale_addr_val", ale_addr, 32'h3001);
        chk("ale_no_req", data_sram_req, 0);
        chk("ale_occ", occ, 0);
        idle(); cycle();

        // Fill the tracker with data_ok withheld, then drain in order
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            idle(); data_sram_addr_ok = 1;
            load(32'h4000 + 32'(4 * acc), 2'd2, 0, 5'(10 + acc));
            cycle();
            if (m_fire) acc++;
        end
        #1;
        chk("full_in_ready", in_ready, 0);
        chk("full_occ", occ, 4);
        idle();
        for (int i = 0; i < 4; i++) begin
            idle(); data_sram_data_ok = 1; data_sram_rdata = 32'(i);
            cycle();
            chk("drain_valid", out_valid, 1);
            chk("drain_dest", out_dest, 10 + i);
        end
        idle(); cycle();

        // Flush three outstanding loads
        for (int i = 0; i < 3; i++) begin
            idle(); data_sram_addr_ok = 1;
            load(32'h5000 + 32'(4 * i), 2'd2, 0, 5'(20 + i));
            cycle();
        end
        idle(); data_sram_addr_ok = 1; cycle();
        idle(); flush = 1; cycle();
        for (int i = 0; i < 3; i++) begin
            idle(); data_sram_data_ok = 1;
            cycle();
            chk("flushed_no_valid", out_valid, 0);
        end
        idle(); data_sram_addr_ok = 1; load(32'h6000, 2'd2, 0, 5'd25);
        cycle();
        idle(); data_sram_addr_ok = 1; cycle();
        idle(); data_sram_data_ok = 1; data_sram_rdata = 32'hCAFE_F00D; cycle();
        chk("post_flush_valid", out_valid, 1);
        chk("post_flush_dest", out_dest, 25);
        chk("post_flush_rdata", out_rdata, 32'hCAFE_F00D);
        idle(); cycle();
        chk("post_flush_occ", occ, 0);

        // Reset with two ops in flight
        idle(); data_sram_addr_ok = 1; load(32'h7000, 2'd2, 0, 5'd2); cycle();
        idle(); data_sram_addr_ok = 1; load(32'h7004, 2'd2, 0, 5'd4); cycle();
        idle(); rstn = 0; cycle();
        idle();
        chk("mid_rst_occ", occ, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", out_valid, 0);
        data_sram_data_ok = 1; cycle();
        chk("late_data_ok_valid", out_valid, 0);
        chk("late_data_ok_occ", occ, 0);
        idle(); cycle();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rand_inputs();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
